// File: rtl/ula_pkg.sv
// Shared ALU definitions: opcode map and the ALU control-state encoding.
// The processor control unit imports the same opcode constants.
package ula_pkg;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] NAN = 3'b010;
    localparam logic [2:0] MUL = 3'b011;
    localparam logic [2:0] OUT = 3'b100;
    localparam logic [2:0] LDI = 3'b101;
    localparam logic [2:0] SHL = 3'b110;
    localparam logic [2:0] REP = 3'b111;

    // ST_ prefix keeps the MUL state apart from the MUL opcode constant
    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

endpackage

// File: rtl/ula_mul_seq.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps per product.
// product is the accumulator value *after* the current step, so the controller
// can register the final result on the same edge that performs the last addition.
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc_next;

    // Add the shifted multiplicand whenever the current multiplier LSB is set
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign product = acc_next;
    assign last    = (count == CW'(WIDTH - 1));

    // Load latches the operands; each step consumes one multiplier bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle ops register in one edge, MUL runs WIDTH steps
// on the sequential multiplier; result and Z/N/C flags are registered together.
module ula_mc
    import ula_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opSelect,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rG,
    output logic             flagZ,
    output logic             flagN,
    output logic             flagC,
    output logic             busy,
    output logic             done
);

    state_e state;
    state_e next_state;

    logic load;
    logic step;
    logic write_single;
    logic write_mul;
    logic mul_last;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   shl_ext;
    logic [SHW-1:0]   shamt;

    ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .mcand_in (rA),
        .mplier_in(b),
        .last     (mul_last),
        .product  (mul_product)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control: start is only honoured in IDLE
    always_comb begin
        next_state   = state;
        load         = 1'b0;
        step         = 1'b0;
        write_single = 1'b0;
        write_mul    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (opSelect == MUL) begin
                        load       = 1'b1;
                        next_state = ST_MUL;
                    end else begin
                        write_single = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                step = 1'b1;
                if (mul_last) begin
                    write_mul  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_MUL);

    // Single-cycle result and carry; the extra top bit of each extended
    // value is the carry, borrow or last bit shifted out respectively
    always_comb begin
        shamt     = b[SHW-1:0];
        sum_ext   = {1'b0, rA} + {1'b0, b};
        diff_ext  = {1'b0, rA} - {1'b0, b};
        shl_ext   = {1'b0, rA} << shamt;
        alu_res   = rA;
        alu_carry = 1'b0;
        case (opSelect)
            ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            NAN: alu_res = ~(rA & b);
            SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            default: begin
                alu_res   = rA;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Result/flag registers and the one-cycle done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rG    <= '0;
            flagZ <= 1'b0;
            flagN <= 1'b0;
            flagC <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= write_single | write_mul;
            if (write_single) begin
                rG    <= alu_res;
                flagZ <= (alu_res == '0);
                flagN <= alu_res[WIDTH-1];
                flagC <= alu_carry;
            end else if (write_mul) begin
                rG    <= mul_product[WIDTH-1:0];
                flagZ <= (mul_product[WIDTH-1:0] == '0);
                flagN <= mul_product[WIDTH-1];
                flagC <= |mul_product[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule
